// File: rtl/kitchen_tile_renderer.sv
// Tile-map renderer for the kitchen play area: 2-bit tile RAM, 3-stage colour pipeline.
// Optional TILE_BORDER_EN macro darkens the top/left pixel row/column of every tile.
module kitchen_tile_renderer #(
  parameter int          MAP_COLS      = 13,
  parameter int          MAP_ROWS      = 8,
  parameter int          TILE_LOG2     = 5,
  parameter int          X_ORIGIN      = 101,
  parameter int          Y_ORIGIN      = 99,
  parameter logic [11:0] COLOR_FLOOR   = 12'h971,
  parameter logic [11:0] COLOR_COUNTER = 12'hB70,
  parameter logic [11:0] COLOR_STOVE   = 12'h333,
  parameter logic [11:0] COLOR_BIN     = 12'h555
) (
  input  logic                        pixel_clk_in,
  input  logic                        rst_in,
  input  logic [10:0]                 hcount_in,
  input  logic [9:0]                  vcount_in,
  input  logic                        wr_valid_in,
  input  logic [$clog2(MAP_COLS)-1:0] wr_col_in,
  input  logic [$clog2(MAP_ROWS)-1:0] wr_row_in,
  input  logic [1:0]                  wr_type_in,
  output logic                        wr_ready_out,
  output logic                        wr_err_out,
  output logic                        init_done_out,
  output logic [11:0]                 pixel_out
);
  localparam int CW = $clog2(MAP_COLS);
  localparam int RW = $clog2(MAP_ROWS);
  localparam int N  = MAP_COLS * MAP_ROWS;
  localparam int AW = $clog2(N);
  localparam logic [11:0] AREA_W = 12'(MAP_COLS << TILE_LOG2);
  localparam logic [11:0] AREA_H = 12'(MAP_ROWS << TILE_LOG2);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state;
  logic [AW-1:0] sweep;
  logic [CW-1:0] sweep_col;
  logic [RW-1:0] sweep_row;
  logic [1:0]    mem [N];

  logic          accept;
  logic          wr_in_range;
  logic [AW-1:0] wr_addr;
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [1:0]    ram_wd;
  logic          perimeter;

  assign accept      = wr_valid_in && wr_ready_out;
  assign wr_in_range = ({1'b0, wr_col_in} < (CW+1)'(MAP_COLS))
                    && ({1'b0, wr_row_in} < (RW+1)'(MAP_ROWS));
  assign wr_addr = AW'(wr_row_in) * AW'(MAP_COLS) + AW'(wr_col_in);
  assign perimeter = (sweep_row == '0)
                  || (sweep_row == RW'(MAP_ROWS-1))
                  || (sweep_col == '0)
                  || (sweep_col == CW'(MAP_COLS-1));

  // The init sweep owns the write port until RUN; reset blocks stray writes.
  assign ram_we = !rst_in
               && ((state == INIT) || (accept && wr_in_range));
  assign ram_wa = (state == INIT) ? sweep : wr_addr;
  assign ram_wd = (state == INIT) ? {1'b0, perimeter} : wr_type_in;

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= INIT;
      sweep         <= '0;
      sweep_col     <= '0;
      sweep_row     <= '0;
      wr_ready_out  <= 1'b0;
      init_done_out <= 1'b0;
      wr_err_out    <= 1'b0;
    end else begin
      wr_err_out <= 1'b0;
      unique case (state)
        INIT: begin
          if (sweep == AW'(N-1)) begin
            state         <= RUN;
            wr_ready_out  <= 1'b1;
            init_done_out <= 1'b1;
          end else begin
            sweep <= sweep + 1'b1;
            if (sweep_col == CW'(MAP_COLS-1)) begin
              sweep_col <= '0;
              sweep_row <= sweep_row + 1'b1;
            end else begin
              sweep_col <= sweep_col + 1'b1;
            end
          end
        end
        RUN: wr_err_out <= accept && !wr_in_range;
      endcase
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (ram_we) mem[ram_wa] <= ram_wd;
  end

  logic [11:0] dx, dy;
  logic        in_area;

  // Unsigned wrap makes left/above-origin coordinates fail the range test.
  assign dx = {1'b0, hcount_in} - 12'(X_ORIGIN);
  assign dy = {2'b0, vcount_in} - 12'(Y_ORIGIN);
  assign in_area = (dx < AREA_W) && (dy < AREA_H);

  logic          s1_in_area, s2_in_area;
  logic [AW-1:0] s1_addr;
  logic [1:0]    rd_type;
  logic [11:0]   tile_color;

  always_comb begin
    tile_color = COLOR_FLOOR;
    unique case (rd_type)
      2'd0: tile_color = COLOR_FLOOR;
      2'd1: tile_color = COLOR_COUNTER;
      2'd2: tile_color = COLOR_STOVE;
      2'd3: tile_color = COLOR_BIN;
    endcase
  end

`ifdef TILE_BORDER_EN
  logic [TILE_LOG2-1:0] s1_fx, s1_fy, s2_fx, s2_fy;
  logic                 tile_edge;
  logic [11:0]          shade;

  assign tile_edge = (s2_fx == '0) || (s2_fy == '0);
  assign shade = tile_edge
    ? {1'b0, tile_color[11:9], 1'b0, tile_color[7:5],
       1'b0, tile_color[3:1]}
    : tile_color;

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_fx <= '0;
      s1_fy <= '0;
      s2_fx <= '0;
      s2_fy <= '0;
    end else begin
      s1_fx <= dx[TILE_LOG2-1:0];
      s1_fy <= dy[TILE_LOG2-1:0];
      s2_fx <= s1_fx;
      s2_fy <= s1_fy;
    end
  end
`else
  logic [11:0] shade;
  assign shade = tile_color;
`endif

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_in_area <= 1'b0;
      s1_addr    <= '0;
      s2_in_area <= 1'b0;
      rd_type    <= '0;
      pixel_out  <= '0;
    end else begin
      s1_in_area <= in_area;
      // Out-of-area pixels read entry 0 so the address stays in range.
      s1_addr <= in_area
        ? AW'((dy >> TILE_LOG2) * 12'(MAP_COLS) + (dx >> TILE_LOG2))
        : '0;
      s2_in_area <= s1_in_area;
      rd_type    <= mem[s1_addr];
      pixel_out  <= (s2_in_area && state == RUN) ? shade : 12'h000;
    end
  end
endmodule

// File: tb/tb_kitchen_tile_renderer.sv
// Scoreboard bench for kitchen_tile_renderer: directed pixels/writes, queued expectations.
module tb_kitchen_tile_renderer;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] h;
  logic [9:0]  v;
  logic        wv;
  logic [3:0]  wc;
  logic [2:0]  wr_row;
  logic [1:0]  wt;
  logic        ready, err, done;
  logic [11:0] pix;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

`ifdef TILE_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [11:0] exp;
    string       name;
  } exp_t;
  exp_t q[$];

  kitchen_tile_renderer dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .hcount_in    (h),
    .vcount_in    (v),
    .wr_valid_in  (wv),
    .wr_col_in    (wc),
    .wr_row_in    (wr_row),
    .wr_type_in   (wt),
    .wr_ready_out (ready),
    .wr_err_out   (err),
    .init_done_out(done),
    .pixel_out    (pix)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [11:0] shade(input logic [11:0] c,
                                        input bit edge_px);
    if (edge_px && BORDER)
      return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one pixel for a cycle; its colour is due three edges later.
  task automatic px(input int x, input int y, input logic [11:0] e,
                    input string n);
    h = 11'(x);
    v = 10'(y);
    q.push_back('{cyc + 3, e, n});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (pix !== e.exp || e.due != cyc) begin
        failures++;
        $display("FAIL %s: pixel_out=%h expected %h (due %0d, seen %0d)",
                 e.name, pix, e.exp, e.due, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic run_init(input string tag);
    int n;
    int r;
    r = cyc;
    n = 0;
    chk({tag, "_ready0"}, ready, 0);
    while (!ready && n < 200) begin
      px(140, 140, (cyc + 3 >= r + 105) ? 12'h971 : 12'h000, {tag, "_px"});
      n++;
    end
    chk({tag, "_len"}, n, 104);
    chk({tag, "_done"}, done, 1);
  endtask

  initial begin
    int stalls;
    rst = 1'b1;
    wv = 1'b0;
    wc = '0;
    wr_row = '0;
    wt = '0;
    h = '0;
    v = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix", pix, 0);
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    run_init("init");

    px(101, 99, shade(12'hB70, 1), "origin");
    px(140, 140, shade(12'h971, 0), "floor");
    px(100, 99, 12'h000, "left_out");
    px(517, 99, 12'h000, "right_out");
    px(101, 98, 12'h000, "top_out");
    px(101, 355, 12'h000, "bottom_out");
    px(516, 354, shade(12'hB70, 0), "last_px");

    wv = 1'b1; wc = 4'd1; wr_row = 3'd1; wt = 2'd2;
    px(0, 0, 12'h000, "wr_idle");
    wv = 1'b0;
    px(133, 131, shade(12'h333, 1), "wr_render");

    wv = 1'b1; wc = 4'd13; wr_row = 3'd0; wt = 2'd3;
    px(0, 0, 12'h000, "oor_idle");
    wv = 1'b0;
    chk("oor_err_pulse", err, 1);
    px(0, 0, 12'h000, "oor_idle2");
    chk("oor_err_clear", err, 0);
    px(485, 99, shade(12'hB70, 1), "oor_row0");
    px(101, 131, shade(12'hB70, 1), "oor_alias");
    px(101, 99, shade(12'hB70, 1), "oor_origin");

    stalls = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 13; c++) begin
        wv = 1'b1; wc = 4'(c); wr_row = 3'(r); wt = 2'd3;
        if (!ready) stalls++;
        px(0, 0, 12'h000, "b2b_idle");
      end
    end
    wv = 1'b0;
    chk("b2b_no_stall", stalls, 0);
    px(101, 99, shade(12'h555, 1), "b2b_origin");
    px(140, 140, shade(12'h555, 0), "b2b_floor");
    px(133, 131, shade(12'h555, 1), "b2b_stove");
    px(516, 354, shade(12'h555, 0), "b2b_last");
    px(300, 200, shade(12'h555, 0), "b2b_mid");

    wv = 1'b1; wc = 4'd2; wr_row = 3'd2; wt = 2'd0;
    px(140, 140, shade(12'h555, 0), "pre_rst_a");
    px(140, 140, shade(12'h555, 0), "pre_rst_b");
    px(140, 140, shade(12'h555, 0), "pre_rst_c");
    chk("pre_rst_pix", pix, 32'(shade(12'h555, 0)));
    #1;
    rst = 1'b1;
    #1;
    q.delete();
    wv = 1'b0;
    chk("mid_rst_pix", pix, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_init("reinit");
    px(101, 99, shade(12'hB70, 1), "re_origin");
    px(140, 140, shade(12'h971, 0), "re_floor");
    px(133, 131, shade(12'h971, 1), "re_cell11");
    px(516, 354, shade(12'hB70, 0), "re_last");
    px(485, 99, shade(12'hB70, 1), "re_row0");

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
